// File: rtl/rfid_ram_pkg.sv
// Shared types and constants for the RFID capture RAM.
package rfid_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } cap_state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic logic rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/rfid_ram_sp.sv
// Single-port byte-enabled RAM, read-first, with optional second output register.
module rfid_ram_sp
  import rfid_ram_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 13,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [NBYTES-1:0]        be,
  input  logic [NBYTES*BYTE_W-1:0] wdata,
  output logic [NBYTES*BYTE_W-1:0] rdata
);

  logic [NBYTES-1:0][BYTE_W-1:0] mem [2**ADDR_W];
  logic [NBYTES*BYTE_W-1:0]      q1;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be[b]) mem[addr][b] <= wdata[b*BYTE_W +: BYTE_W];
      end
    end
    if (re) q1 <= mem[addr];
  end

  generate
    if (RD_LAT >= RD_LAT_MAX) begin : g_out_reg
      logic [NBYTES*BYTE_W-1:0] q2;
      always_ff @(posedge clk) q2 <= q1;
      assign rdata = q2;
    end else begin : g_no_out_reg
      assign rdata = q1;
    end
  endgenerate

endmodule

// File: rtl/rfid_capture_ram.sv
// Capture RAM: streams cap_data into memory under a small FSM, Avalon-MM access on the same port.
// Optional per-byte even parity with par_err output when RFID_RAM_PARITY_EN is defined.
//   state | meaning
//   IDLE  | never armed since reset, stream not accepted
//   FILL  | accepting stream beats into word cap_count
//   DONE  | cap_len words captured, waiting for re-arm
module rfid_capture_ram
  import rfid_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  output logic                s_waitrequest,
  input  logic                cap_valid,
  input  logic [DATA_W-1:0]   cap_data,
  output logic                cap_ready,
  input  logic                arm,
  input  logic [ADDR_W:0]     cap_len,
  output logic                cap_busy,
  output logic                cap_done,
  output logic [ADDR_W:0]     cap_count
`ifdef RFID_RAM_PARITY_EN
  ,
  output logic                par_err
`endif
);

  localparam int NB  = DATA_W / 8;
  localparam int LAT = rd_lat_legal(RD_LAT) ? RD_LAT : RD_LAT_MIN;
`ifdef RFID_RAM_PARITY_EN
  localparam int BW = 9;
`else
  localparam int BW = 8;
`endif
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  cap_state_t          state;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     count_inc;
  logic                cap_we, av_wr, av_rd;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [NB-1:0]       ram_be;
  logic [DATA_W-1:0]   wr_data, rd_data;
  logic [NB*BW-1:0]    ram_wdata, ram_rdata;
  logic [LAT-1:0]      vpipe;

  assign cap_we    = cap_ready & cap_valid;
  assign count_inc = cap_count + 1'b1;

  // len_q never exceeds DEPTH, so stopping at len_q also saturates cap_count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cap_count <= '0;
      len_q     <= '0;
      cap_ready <= 1'b0;
      cap_busy  <= 1'b0;
      cap_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm && cap_len != '0) begin
            state     <= ST_FILL;
            cap_count <= '0;
            len_q     <= (cap_len > DEPTH) ? DEPTH : cap_len;
            cap_ready <= 1'b1;
            cap_busy  <= 1'b1;
            cap_done  <= 1'b0;
          end
        end
        ST_FILL: begin
          if (cap_we) begin
            cap_count <= count_inc;
            if (count_inc == len_q) begin
              state     <= ST_DONE;
              cap_ready <= 1'b0;
              cap_busy  <= 1'b0;
              cap_done  <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          cap_ready <= 1'b0;
          cap_busy  <= 1'b0;
          cap_done  <= 1'b0;
        end
      endcase
    end
  end

  assign s_waitrequest = cap_we & (s_read | s_write);
  assign av_wr         = s_write & ~s_waitrequest;
  assign av_rd         = s_read & ~s_write & ~s_waitrequest;

  assign ram_we   = cap_we | av_wr;
  assign ram_addr = cap_we ? cap_count[ADDR_W-1:0] : s_address;
  assign ram_be   = cap_we ? '1 : s_byteenable;
  assign wr_data  = cap_we ? cap_data : s_writedata;

  always_comb begin
    ram_wdata = '0;
    for (int b = 0; b < NB; b++) begin
      ram_wdata[b*BW +: 8] = wr_data[b*8 +: 8];
`ifdef RFID_RAM_PARITY_EN
      ram_wdata[b*BW + 8] = ^wr_data[b*8 +: 8];
`endif
    end
  end

  rfid_ram_sp #(
    .NBYTES (NB),
    .BYTE_W (BW),
    .ADDR_W (ADDR_W),
    .RD_LAT (LAT)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (av_rd),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  generate
    if (LAT >= RD_LAT_MAX) begin : g_valid2
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vpipe <= '0;
        else          vpipe <= {vpipe[0], av_rd};
      end
    end else begin : g_valid1
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vpipe <= '0;
        else          vpipe <= av_rd;
      end
    end
  endgenerate

  assign s_readdatavalid = vpipe[LAT-1];

`ifdef RFID_RAM_PARITY_EN
  logic [NB-1:0] par_bad;
`endif

  always_comb begin
    rd_data = '0;
`ifdef RFID_RAM_PARITY_EN
    par_bad = '0;
`endif
    for (int b = 0; b < NB; b++) begin
      rd_data[b*8 +: 8] = ram_rdata[b*BW +: 8];
`ifdef RFID_RAM_PARITY_EN
      par_bad[b] = ^ram_rdata[b*BW +: BW];
`endif
    end
  end

  // RAM output registers carry no reset, so the bus sees zero outside valid beats.
  assign s_readdata = s_readdatavalid ? rd_data : '0;

`ifdef RFID_RAM_PARITY_EN
  assign par_err = s_readdatavalid & (|par_bad);
`endif

endmodule

// File: tb/tb_rfid_capture_ram.sv
// Self-checking bench for rfid_capture_ram: directed scenarios plus randomized traffic vs a word-array model.
module tb_rfid_capture_ram;

  localparam int DW = 32;
  localparam int AW = 13;
  localparam int RL = 2;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] s_address = '0;
  logic [3:0]    s_byteenable = '0;
  logic          s_read = 1'b0, s_write = 1'b0;
  logic [DW-1:0] s_writedata = '0;
  logic [DW-1:0] s_readdata;
  logic          s_readdatavalid, s_waitrequest;
  logic          cap_valid = 1'b0;
  logic [DW-1:0] cap_data = '0;
  logic          cap_ready;
  logic          arm = 1'b0;
  logic [AW:0]   cap_len = '0;
  logic          cap_busy, cap_done;
  logic [AW:0]   cap_count;
`ifdef RFID_RAM_PARITY_EN
  logic          par_err;
`endif

  int total = 0;
  int bad = 0;
  logic [DW-1:0] model [DEPTH];

  typedef struct { int due; logic [DW-1:0] d; } rd_t;
  rd_t exp_q[$];

  always #5 clk = ~clk;

  rfid_capture_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_waitrequest(s_waitrequest),
    .cap_valid(cap_valid), .cap_data(cap_data), .cap_ready(cap_ready),
    .arm(arm), .cap_len(cap_len), .cap_busy(cap_busy), .cap_done(cap_done), .cap_count(cap_count)
`ifdef RFID_RAM_PARITY_EN
    , .par_err(par_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic av_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    s_address = a; s_writedata = d; s_byteenable = be; s_write = 1'b1;
    step();
    s_write = 1'b0;
    for (int b = 0; b < 4; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic av_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    s_address = a; s_read = 1'b1;
    step();
    s_read = 1'b0;
    lat = 1;
    while (!s_readdatavalid && lat < 8) begin step(); lat++; end
    d = s_readdata;
    if (!s_readdatavalid) lat = -1;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (cap_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cap_count); end
    total++; if ({cap_busy, cap_done, cap_ready} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {cap_busy, cap_done, cap_ready}); end
    total++; if (s_readdatavalid !== 1'b0 || s_readdata !== '0) begin bad++; $display("FAIL reset_rd got=%b/%h exp=0/0", s_readdatavalid, s_readdata); end
    reset_n = 1'b1;
    step();
    arm = 1'b1; cap_len = '0;
    step();
    arm = 1'b0;
    total++; if (cap_busy !== 1'b0 || cap_ready !== 1'b0) begin bad++; $display("FAIL arm_len0_idle got=%b%b exp=00", cap_busy, cap_ready); end
    total++; if (s_waitrequest !== 1'b0) begin bad++; $display("FAIL idle_waitreq got=%b exp=0", s_waitrequest); end
  endtask

  task automatic test_byteenable();
    logic [DW-1:0] d; int lat;
    av_write(13'd3, 32'hFFFF_FFFF, 4'hF);
    av_write(13'd3, 32'hA5A5_A5A5, 4'b0101);
    av_read(13'd3, d, lat);
    total++; if (d !== 32'hFFA5_FFA5) begin bad++; $display("FAIL be_data got=%h exp=ffa5ffa5", d); end
    total++; if (lat != RL) begin bad++; $display("FAIL be_latency got=%0d exp=%0d", lat, RL); end
  endtask

  task automatic test_capture();
    logic [11:0] pat; int sent; logic [DW-1:0] d; int lat;
    pat = 12'b0110_1101_0101;
    arm = 1'b1; cap_len = 14'd4;
    step();
    arm = 1'b0;
    total++; if ({cap_busy, cap_ready, cap_done} !== 3'b110 || cap_count !== '0) begin bad++; $display("FAIL cap_start got=%b cnt=%0d exp=110 cnt=0", {cap_busy, cap_ready, cap_done}, cap_count); end
    sent = 0;
    for (int i = 0; i < 12 && sent < 4; i++) begin
      cap_valid = pat[i]; cap_data = 32'h10 + sent;
      step();
      if (pat[i]) begin model[sent] = 32'h10 + sent; sent++; end
    end
    cap_valid = 1'b0;
    total++; if (cap_count !== 14'd4 || cap_done !== 1'b1) begin bad++; $display("FAIL cap_end got=cnt%0d done%b exp=cnt4 done1", cap_count, cap_done); end
    total++; if (cap_ready !== 1'b0 || cap_busy !== 1'b0) begin bad++; $display("FAIL cap_ready_after got=%b%b exp=00", cap_ready, cap_busy); end
    cap_valid = 1'b1; cap_data = 32'hDEAD_BEEF;
    step(); step();
    cap_valid = 1'b0;
    total++; if (cap_count !== 14'd4) begin bad++; $display("FAIL cap_no_overrun got=%0d exp=4", cap_count); end
    for (int a = 0; a < 4; a++) begin
      av_read(AW'(a), d, lat);
      total++; if (d !== 32'h10 + a || lat != RL) begin bad++; $display("FAIL cap_word%0d got=%h lat%0d exp=%h lat%0d", a, d, lat, 32'h10 + a, RL); end
    end
  endtask

  task automatic test_priority();
    logic [DW-1:0] d; int lat;
    av_write(13'd5, 32'h5555_AAAA, 4'hF);
    arm = 1'b1; cap_len = 14'd2;
    step();
    arm = 1'b0;
    cap_valid = 1'b1; cap_data = 32'h77; s_read = 1'b1; s_address = 13'd5;
    #1;
    total++; if (s_waitrequest !== 1'b1) begin bad++; $display("FAIL prio_rd_stall got=%b exp=1", s_waitrequest); end
    step();
    model[0] = 32'h77;
    cap_valid = 1'b0;
    #1;
    total++; if (s_waitrequest !== 1'b0) begin bad++; $display("FAIL prio_rd_release got=%b exp=0", s_waitrequest); end
    step();
    s_read = 1'b0;
    for (int k = 1; k < RL; k++) begin
      total++; if (s_readdatavalid !== 1'b0) begin bad++; $display("FAIL prio_early_valid got=1 exp=0"); end
      step();
    end
    total++; if (s_readdatavalid !== 1'b1 || s_readdata !== model[5]) begin bad++; $display("FAIL prio_rd_data got=%b/%h exp=1/%h", s_readdatavalid, s_readdata, model[5]); end
    cap_valid = 1'b1; cap_data = 32'h78;
    s_write = 1'b1; s_address = 13'd6; s_writedata = 32'h1234_5678; s_byteenable = 4'hF;
    #1;
    total++; if (s_waitrequest !== 1'b1) begin bad++; $display("FAIL prio_wr_stall got=%b exp=1", s_waitrequest); end
    step();
    cap_valid = 1'b0;
    step();
    s_write = 1'b0;
    model[1] = 32'h78; model[6] = 32'h1234_5678;
    total++; if (cap_done !== 1'b1 || cap_count !== 14'd2) begin bad++; $display("FAIL prio_done got=%b cnt%0d exp=1 cnt2", cap_done, cap_count); end
    av_read(13'd6, d, lat);
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL prio_wr_data got=%h exp=12345678", d); end
    av_read(13'd1, d, lat);
    total++; if (d !== 32'h78) begin bad++; $display("FAIL prio_cap_data got=%h exp=00000078", d); end
  endtask

  task automatic test_back_to_back();
    int nvalid; logic expv;
    nvalid = 0;
    for (int e = 0; e < 6; e++) begin
      s_read = (e < 3); s_address = AW'(e);
      step();
      expv = (e + 1 >= RL) && (e + 1 <= RL + 2);
      total++;
      if (s_readdatavalid !== expv) begin bad++; $display("FAIL b2b_valid edge%0d got=%b exp=%b", e + 1, s_readdatavalid, expv); end
      else if (expv && s_readdata !== model[e + 1 - RL]) begin bad++; $display("FAIL b2b_data edge%0d got=%h exp=%h", e + 1, s_readdata, model[e + 1 - RL]); end
    end
    s_read = 1'b0;
  endtask

  task automatic test_arm_ignore();
    arm = 1'b1; cap_len = '0;
    step();
    arm = 1'b0;
    total++; if (cap_done !== 1'b1 || cap_busy !== 1'b0) begin bad++; $display("FAIL arm_len0_done got=%b%b exp=10", cap_done, cap_busy); end
    arm = 1'b1; cap_len = 14'd3;
    step();
    arm = 1'b0;
    total++; if (cap_busy !== 1'b1 || cap_count !== '0) begin bad++; $display("FAIL rearm got=%b cnt%0d exp=1 cnt0", cap_busy, cap_count); end
    cap_valid = 1'b1; cap_data = 32'h30;
    step();
    arm = 1'b1; cap_len = 14'd1; cap_data = 32'h31;
    step();
    arm = 1'b0;
    total++; if (cap_count !== 14'd2 || cap_busy !== 1'b1) begin bad++; $display("FAIL arm_in_fill got=cnt%0d busy%b exp=cnt2 busy1", cap_count, cap_busy); end
    cap_data = 32'h32;
    step();
    cap_valid = 1'b0;
    model[0] = 32'h30; model[1] = 32'h31; model[2] = 32'h32;
    total++; if (cap_count !== 14'd3 || cap_done !== 1'b1) begin bad++; $display("FAIL arm_fill_end got=cnt%0d done%b exp=cnt3 done1", cap_count, cap_done); end
  endtask

  task automatic test_random();
    int op, cyc; logic [AW-1:0] a; logic expv;
    for (int i = 0; i < 16; i++) av_write(AW'(i), $urandom, 4'hF);
    cyc = 0;
    exp_q.delete();
    for (int i = 0; i < 300 + RL + 1; i++) begin
      op = (i < 300) ? int'($urandom_range(0, 4)) : 0;
      a = AW'($urandom_range(0, 15));
      s_address = a; s_byteenable = 4'($urandom); s_writedata = $urandom;
      s_write = (op == 1 || op == 3);
      s_read = (op == 2 || op == 3);
      #1;
      total++; if (s_waitrequest !== 1'b0) begin bad++; $display("FAIL rnd_waitreq cyc%0d got=1 exp=0", cyc); end
      if (s_write) begin
        for (int b = 0; b < 4; b++) if (s_byteenable[b]) model[a][b*8 +: 8] = s_writedata[b*8 +: 8];
      end else if (s_read) begin
        exp_q.push_back('{cyc + RL, model[a]});
      end
      step();
      cyc++;
      expv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      total++;
      if (s_readdatavalid !== expv) begin bad++; $display("FAIL rnd_valid cyc%0d got=%b exp=%b", cyc, s_readdatavalid, expv); end
      else if (expv) begin
        if (s_readdata !== exp_q[0].d) begin bad++; $display("FAIL rnd_data cyc%0d got=%h exp=%h", cyc, s_readdata, exp_q[0].d); end
        void'(exp_q.pop_front());
      end
    end
    s_read = 1'b0; s_write = 1'b0;
  endtask

  task automatic test_random_capture();
    int len, sent, guard, lat; logic [DW-1:0] d;
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 12);
      arm = 1'b1; cap_len = 14'(len);
      step();
      arm = 1'b0;
      sent = 0; guard = 0;
      while (sent < len && guard < 200) begin
        cap_valid = 1'($urandom); cap_data = $urandom;
        if (cap_valid) model[sent] = cap_data;
        step();
        if (cap_valid) sent++;
        guard++;
        total++; if (cap_count !== 14'(sent) || cap_busy !== (sent < len)) begin bad++; $display("FAIL rcap_count r%0d got=%0d busy%b exp=%0d", r, cap_count, cap_busy, sent); end
      end
      cap_valid = 1'b0;
      total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL rcap_done r%0d got=%b exp=1", r, cap_done); end
      for (int a = 0; a < len; a++) begin
        av_read(AW'(a), d, lat);
        total++; if (d !== model[a]) begin bad++; $display("FAIL rcap_word r%0d a%0d got=%h exp=%h", r, a, d, model[a]); end
      end
    end
  endtask

  task automatic test_clamp();
    logic [DW-1:0] d; int lat;
    arm = 1'b1; cap_len = 14'h3FFF;
    step();
    arm = 1'b0;
    cap_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cap_data = 32'hC300_0000 ^ i;
      if (i == DEPTH - 1) begin
        total++; if (cap_busy !== 1'b1 || cap_count !== 14'(DEPTH - 1)) begin bad++; $display("FAIL clamp_pre got=busy%b cnt%0d exp=busy1 cnt%0d", cap_busy, cap_count, DEPTH - 1); end
      end
      step();
      model[i] = 32'hC300_0000 ^ i;
    end
    step();
    cap_valid = 1'b0;
    total++; if (cap_count !== 14'(DEPTH) || cap_done !== 1'b1 || cap_ready !== 1'b0) begin bad++; $display("FAIL clamp_end got=cnt%0d done%b rdy%b exp=cnt%0d done1 rdy0", cap_count, cap_done, cap_ready, DEPTH); end
    av_read(AW'(DEPTH - 1), d, lat);
    total++; if (d !== model[DEPTH - 1]) begin bad++; $display("FAIL clamp_last got=%h exp=%h", d, model[DEPTH - 1]); end
    av_read(13'd4097, d, lat);
    total++; if (d !== model[4097]) begin bad++; $display("FAIL clamp_mid got=%h exp=%h", d, model[4097]); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d; int lat;
    arm = 1'b1; cap_len = 14'd8;
    step();
    arm = 1'b0;
    cap_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cap_data = 32'hE0 + i;
      step();
      model[i] = 32'hE0 + i;
    end
    cap_data = 32'hEE;
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (cap_count !== '0 || {cap_busy, cap_ready, cap_done} !== 3'b000) begin bad++; $display("FAIL rstmid_async got=cnt%0d flags%b exp=cnt0 flags000", cap_count, {cap_busy, cap_ready, cap_done}); end
    step(); step();
    reset_n = 1'b1;
    step(); step(); step();
    total++; if (cap_count !== '0 || {cap_busy, cap_ready, cap_done} !== 3'b000) begin bad++; $display("FAIL rstmid_idle got=cnt%0d flags%b exp=cnt0 flags000", cap_count, {cap_busy, cap_ready, cap_done}); end
    cap_valid = 1'b0;
    for (int a = 0; a < 3; a++) begin
      av_read(AW'(a), d, lat);
      total++; if (d !== model[a]) begin bad++; $display("FAIL rstmid_word%0d got=%h exp=%h", a, d, model[a]); end
    end
  endtask

`ifdef RFID_RAM_PARITY_EN
  task automatic test_parity();
    int seen;
    av_write(13'd7, 32'h0F0F_1234, 4'hF);
    av_write(13'd8, 32'h8765_4321, 4'hF);
    dut.u_ram.mem[7][1][2] = ~dut.u_ram.mem[7][1][2];
    for (int r = 0; r < 2; r++) begin
      s_address = AW'(7 + r); s_read = 1'b1;
      step();
      s_read = 1'b0;
      seen = 0;
      for (int k = 1; k <= RL + 1; k++) begin
        total++; if (par_err !== (s_readdatavalid && r == 0)) begin bad++; $display("FAIL parity r%0d k%0d got=%b exp=%b", r, k, par_err, s_readdatavalid && r == 0); end
        if (s_readdatavalid) seen++;
        step();
      end
      total++; if (seen != 1) begin bad++; $display("FAIL parity_valid r%0d got=%0d exp=1", r, seen); end
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byteenable();
    test_capture();
    test_priority();
    test_back_to_back();
    test_arm_ignore();
    test_random();
    test_random_capture();
    test_clamp();
    test_reset_mid();
`ifdef RFID_RAM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rfid_capture_ram.md
RFID_CAPTURE_RAM -- requirements
Module: rfid_capture_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 13, word address width (depth = 2**ADDR_W).
REQ-003 SHALL have parameter RD_LAT, default 1, Avalon read latency in cycles (legal: 1 or 2).
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports s_address in ADDR_W, s_byteenable in DATA_W/8, s_read in 1, s_write in 1, s_writedata in DATA_W: Avalon-MM slave request.
REQ-007 SHALL have ports s_readdata out DATA_W, s_readdatavalid out 1, s_waitrequest out 1: Avalon-MM slave response.
REQ-008 SHALL have ports cap_valid in 1, cap_data in DATA_W, cap_ready out 1: sample capture stream.
REQ-009 SHALL have ports arm in 1 (pulse), cap_len in ADDR_W+1 (words to capture), cap_busy out 1, cap_done out 1, cap_count out ADDR_W+1.

Function
REQ-010 Capture FSM states SHALL be IDLE, FILL, DONE; IDLE->FILL on arm with cap_len != 0; FILL->DONE when cap_count reaches cap_len; DONE->FILL on arm; arm with cap_len == 0 SHALL be ignored.
REQ-011 On entering FILL, cap_count SHALL clear to 0 and cap_len SHALL be latched; arm during FILL SHALL be ignored.
REQ-012 In FILL, cap_ready SHALL be 1; each cycle with cap_valid & cap_ready SHALL write cap_data (all bytes) to word cap_count and increment cap_count.
REQ-013 cap_ready SHALL be 0 in IDLE and DONE; cap_busy = (state == FILL); cap_done = (state == DONE).
REQ-014 Capture write SHALL have priority: s_waitrequest SHALL be 1 in any cycle where a capture write occurs and s_read or s_write is asserted, else 0.
REQ-015 Accepted Avalon write (s_write & ~s_waitrequest) SHALL update only bytes with s_byteenable set.
REQ-016 Accepted Avalon read SHALL return s_readdata with s_readdatavalid high exactly RD_LAT cycles later, one pulse per read; reads SHALL be pipelined, one per cycle.
REQ-017 Read of an address written in the same cycle SHALL return old data.
REQ-018 s_read and s_write asserted together SHALL be treated as write only; no readdatavalid generated.
REQ-019 cap_count SHALL saturate at 2**ADDR_W; cap_len > 2**ADDR_W SHALL be clamped to 2**ADDR_W when latched.

Reset
REQ-020 On reset_n low: FSM to IDLE, cap_count 0, cap_ready 0, cap_busy 0, cap_done 0, s_readdatavalid 0 and read pipeline flushed, s_readdata 0.
REQ-021 Memory contents SHALL NOT be cleared by reset; reset mid-capture SHALL abort without further writes.

Configuration
REQ-022 With RFID_RAM_PARITY_EN defined, one even-parity bit per byte SHALL be stored on every write and checked on every Avalon read; output par_err (1 bit) SHALL pulse with s_readdatavalid when any byte mismatches; without the macro no parity storage, no par_err port.

Structure
REQ-023 Package rfid_ram_pkg SHALL hold the FSM state enum and RD_LAT legal-value constants.
REQ-024 Storage SHALL be sub-module rfid_ram_sp (single write/read port, byte enables, RD_LAT-configurable output register), inferable as block RAM.

Verification
REQ-025 Avalon write 0xA5A5A5A5 to addr 3, byteenable 0b0101, over 0xFFFFFFFF -> read returns 0xFFA5FFA5 after RD_LAT cycles.
REQ-026 arm with cap_len 4, stream 0x10..0x13 with cap_valid gaps -> cap_count 4, cap_done 1, words 0..3 hold 0x10..0x13, cap_ready 0 afterwards.
REQ-027 Avalon read held during capture beat -> s_waitrequest 1 that cycle, read accepted next cycle, data correct.
REQ-028 Back-to-back reads addr 0,1,2 with RD_LAT=2 -> three readdatavalid pulses on consecutive cycles, in order.
REQ-029 reset_n low after 2 of 8 captured words -> IDLE, cap_count 0, words 0..1 retain data.
REQ-030 RFID_RAM_PARITY_EN: force a stored bit flip via backdoor -> par_err pulses with that read's s_readdatavalid only.
